// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake and unified memory bus of the load/store unit
//  master: requester + memory side (drives req_*, mem_rdata)
//  slave : mem_access_unit (drives req_ready, resp_*, mem_* strobes/data)
interface mem_access_unit_if #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sized load/store front end with alignment/range checks, lane masks and load extension
//  clk, rst : clock, asynchronous active-high reset
//  bus      : mem_access_unit_if.slave (request/response handshake + word-addressed memory port)
//  Params   : ADDR_W memory word-address width, MEM_LATENCY 1..4 cycles from mem_en to mem_rdata
module mem_access_unit #(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state, state_n;
  logic [1:0]        cnt;
  logic [1:0]        lat_a;
  logic [2:0]        lat_f3;
  logic              lat_wr;
  logic              fault;
  logic [3:0]        mask;
  logic [31:0]       rep_data;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [31:0]       ld_data;
  logic              ready_d, valid_d, fault_d, en_d, we_d;
  logic [31:0]       rdata_d, wdata_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        wmask_d;
  // funct3[1:0] encodes width (00 B, 01 H, 10 W); stores have no unsigned forms
  always_comb begin
    fault = (bus.req_write ? (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11)
                           : (bus.req_funct3[1:0] == 2'b11 || bus.req_funct3 == 3'b110))
         || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
         || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
         || (|bus.req_addr[31:ADDR_W+2]);
    mask = bus.req_funct3[1:0] == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
           bus.req_funct3[1:0] == 2'b01 ? 4'b0011 << bus.req_addr[1:0] : 4'b1111;
    rep_data = bus.req_funct3[1:0] == 2'b00 ? {4{bus.req_wdata[7:0]}} :
               bus.req_funct3[1:0] == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req_valid) state_n = fault ? RESP : ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (cnt == 2'd0) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  // cnt is reloaded on every ISSUE, so wrapping after the last WAIT cycle is harmless
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt    <= '0;
      lat_a  <= '0;
      lat_f3 <= '0;
      lat_wr <= 1'b0;
    end else begin
      cnt <= state == ISSUE ? 2'(MEM_LATENCY - 1) : cnt - 2'd1;
      if (state == IDLE && bus.req_valid) begin
        lat_a  <= bus.req_addr[1:0];
        lat_f3 <= bus.req_funct3;
        lat_wr <= bus.req_write;
      end
    end
  always_comb begin
    sel_b   = bus.mem_rdata[{lat_a, 3'b000} +: 8];
    sel_h   = lat_a[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_data = lat_f3[1] ? bus.mem_rdata :
              lat_f3[0] ? {{16{!lat_f3[2] && sel_h[15]}}, sel_h} : {{24{!lat_f3[2] && sel_b[7]}}, sel_b};
  end
  // outputs are computed from the upcoming state and registered, so they change with the state
  always_comb begin
    ready_d = state_n == IDLE;
    valid_d = state_n == RESP;
    fault_d = state == IDLE && state_n == RESP;
    en_d    = state_n == ISSUE;
    we_d    = en_d && bus.req_write;
    rdata_d = !valid_d ? bus.resp_rdata : (state == WAIT && !lat_wr) ? ld_data : 32'd0;
    addr_d  = en_d ? bus.req_addr[ADDR_W+1:2] : bus.mem_addr;
    wmask_d = en_d ? (bus.req_write ? mask : 4'b0000) : bus.mem_wmask;
    wdata_d = en_d ? rep_data : bus.mem_wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wmask  <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.req_ready  <= ready_d;
      bus.resp_valid <= valid_d;
      bus.resp_fault <= fault_d;
      bus.resp_rdata <= rdata_d;
      bus.mem_en     <= en_d;
      bus.mem_we     <= we_d;
      bus.mem_addr   <= addr_d;
      bus.mem_wmask  <= wmask_d;
      bus.mem_wdata  <= wdata_d;
    end
endmodule
